// File: rtl/voice_mixer_if.sv
// Codec/voice-side signal bundle for the three-voice mixer.
// slave = the mixer itself, master = the codec and voice sources driving it.
interface voice_mixer_if;
   logic               new_frame;
   logic               generate_next;
   logic               ready0;
   logic               ready1;
   logic               ready2;
   logic signed [15:0] sample0;
   logic signed [15:0] sample1;
   logic signed [15:0] sample2;
   logic [2:0]         mute;
   logic [1:0]         shift;
   logic signed [15:0] sample_out;
   logic               sample_out_valid;
   logic               busy;
   logic               timeout_pulse;
   logic               overrun;

   modport slave (
      input  new_frame, ready0, ready1, ready2, sample0, sample1, sample2, mute, shift,
      output generate_next, sample_out, sample_out_valid, busy, timeout_pulse, overrun
   );

   modport master (
      output new_frame, ready0, ready1, ready2, sample0, sample1, sample2, mute, shift,
      input  generate_next, sample_out, sample_out_valid, busy, timeout_pulse, overrun
   );
endinterface

// File: rtl/voice_mixer.sv
// Three-voice mixer: per codec frame, requests one sample per voice, waits (bounded by
// TIMEOUT) for them, then sums unmuted voices, attenuates by shift and saturates to 16 bits.
module voice_mixer #(
   parameter int unsigned TIMEOUT = 255
) (
   input logic          clk,
   input logic          reset,
   voice_mixer_if.slave vif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SUM, S_OUT} state_e;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [2:0]         flag_q, flag_d;
   logic [2:0][15:0]   smp_q, smp_d;
   logic [7:0]         timer_q, timer_d;
   logic               gen_q, gen_d;
   logic               tmo_q, tmo_d;
   logic               ovr_q, ovr_d;
   logic signed [15:0] out_q, out_d;

   logic [2:0]         rdy;
   logic [2:0][15:0]   smp_in;
   logic               all_done;
   logic signed [17:0] sum_w, shifted_w;
   logic               busy_w, valid_w;

   assign rdy      = {vif.ready2, vif.ready1, vif.ready0};
   assign smp_in   = {vif.sample2, vif.sample1, vif.sample0};
   // Captures landing on this edge count toward completion.
   assign all_done = &(flag_q | rdy);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         flag_q  <= '0;
         smp_q   <= '0;
         timer_q <= '0;
         gen_q   <= 1'b0;
         tmo_q   <= 1'b0;
         ovr_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         flag_q  <= flag_d;
         smp_q   <= smp_d;
         timer_q <= timer_d;
         gen_q   <= gen_d;
         tmo_q   <= tmo_d;
         ovr_q   <= ovr_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (vif.new_frame) state_d = S_WAIT;
         S_WAIT:  if (all_done || timer_q == TMO_LAST) state_d = S_SUM;
         S_SUM:   state_d = S_OUT;
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      flag_d    = flag_q;
      smp_d     = smp_q;
      timer_d   = timer_q;
      gen_d     = 1'b0;
      tmo_d     = 1'b0;
      out_d     = out_q;
      ovr_d     = ovr_q | (vif.new_frame && state_q != S_IDLE);
      sum_w     = '0;
      shifted_w = '0;
      busy_w    = (state_q != S_IDLE);
      valid_w   = (state_q == S_OUT);

      unique case (state_q)
         S_IDLE: begin
            if (vif.new_frame) begin
               flag_d  = '0;
               smp_d   = '0;
               timer_d = '0;
               gen_d   = 1'b1;
            end
         end
         S_WAIT: begin
            for (int i = 0; i < 3; i++) begin
               if (rdy[i] && !flag_q[i]) begin
                  smp_d[i]  = smp_in[i];
                  flag_d[i] = 1'b1;
               end
            end
            timer_d = timer_q + 8'd1;
            tmo_d   = !all_done && (timer_q == TMO_LAST);
         end
         S_SUM: begin
            // Missing voices were cleared at frame start, so they add zero.
            for (int i = 0; i < 3; i++) begin
               if (!vif.mute[i]) sum_w = sum_w + $signed({{2{smp_q[i][15]}}, smp_q[i]});
            end
            shifted_w = sum_w >>> vif.shift;
            if (shifted_w > 18'sd32767)       out_d = 16'sh7FFF;
            else if (shifted_w < -18'sd32768) out_d = 16'sh8000;
            else                              out_d = shifted_w[15:0];
         end
         default: ;
      endcase
   end

   assign vif.generate_next    = gen_q;
   assign vif.timeout_pulse    = tmo_q;
   assign vif.overrun          = ovr_q;
   assign vif.sample_out       = out_q;
   assign vif.busy             = busy_w;
   assign vif.sample_out_valid = valid_w;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer (TIMEOUT=16): mixing, saturation, mute/shift,
// WAIT timeout and same-edge race, overrun, and mid-frame reset.
module tb_voice_mixer;
   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   gen_cnt = 0, val_cnt = 0, tmo_cnt = 0;
   int   gen_cyc = 0, tmo_cyc = 0;

   voice_mixer_if vif ();

   voice_mixer #(.TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .vif   (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse bookkeeping sampled mid-cycle.
   always @(negedge clk) begin
      if (vif.generate_next === 1'b1) begin
         gen_cnt <= gen_cnt + 1;
         gen_cyc <= cyc;
      end
      if (vif.sample_out_valid === 1'b1) val_cnt <= val_cnt + 1;
      if (vif.timeout_pulse === 1'b1) begin
         tmo_cnt <= tmo_cnt + 1;
         tmo_cyc <= cyc;
      end
   end

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_val(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      vif.new_frame = 1'b1;
      step();
      vif.new_frame = 1'b0;
   endtask

   task automatic give(input logic [2:0] r, input int s0, input int s1, input int s2);
      vif.ready0  = r[0];
      vif.ready1  = r[1];
      vif.ready2  = r[2];
      vif.sample0 = 16'(s0);
      vif.sample1 = 16'(s1);
      vif.sample2 = 16'(s2);
      step();
      vif.ready0 = 1'b0;
      vif.ready1 = 1'b0;
      vif.ready2 = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int exp);
      int n = 0;
      while (vif.sample_out_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk_bit({tag, "_valid_seen"}, vif.sample_out_valid, 1'b1);
      chk_val({tag, "_sample_out"}, 32'(vif.sample_out), exp);
      step();
   endtask

   initial begin
      int bg, bv, bt;
      reset         = 1'b0;
      vif.new_frame = 1'b0;
      vif.ready0    = 1'b0;
      vif.ready1    = 1'b0;
      vif.ready2    = 1'b0;
      vif.sample0   = '0;
      vif.sample1   = '0;
      vif.sample2   = '0;
      vif.mute      = 3'b000;
      vif.shift     = 2'd0;
      step();
      step();
      chk_bit("rst_generate_next", vif.generate_next, 1'b0);
      chk_bit("rst_valid", vif.sample_out_valid, 1'b0);
      chk_bit("rst_busy", vif.busy, 1'b0);
      chk_bit("rst_timeout", vif.timeout_pulse, 1'b0);
      chk_bit("rst_overrun", vif.overrun, 1'b0);
      chk_val("rst_sample_out", 32'(vif.sample_out), 0);
      reset = 1'b1;
      step();

      // Readies on separate cycles; a repeated ready0 must not replace the first capture.
      bg = gen_cnt; bv = val_cnt;
      start_frame();
      chk_bit("t1_gen_high", vif.generate_next, 1'b1);
      chk_bit("t1_busy", vif.busy, 1'b1);
      give(3'b001, 1000, 0, 0);
      chk_bit("t1_gen_low", vif.generate_next, 1'b0);
      give(3'b010, 0, 2000, 0);
      give(3'b101, 7, 0, -500);
      wait_valid("t1", 2500);
      chk_bit("t1_valid_one_cycle", vif.sample_out_valid, 1'b0);
      chk_bit("t1_idle", vif.busy, 1'b0);
      chk_val("t1_gen_count", gen_cnt - bg, 1);
      chk_val("t1_valid_count", val_cnt - bv, 1);

      // Simultaneous readies, positive saturation, exact latency.
      start_frame();
      give(3'b111, 30000, 30000, 30000);
      chk_bit("t2_no_valid_in_sum", vif.sample_out_valid, 1'b0);
      step();
      chk_bit("t2_valid_m2", vif.sample_out_valid, 1'b1);
      chk_val("t2_pos_sat", 32'(vif.sample_out), 32767);
      step();
      chk_bit("t2_valid_dropped", vif.sample_out_valid, 1'b0);
      chk_bit("t2_overrun_clear", vif.overrun, 1'b0);

      start_frame();
      give(3'b111, -30000, -30000, -30000);
      wait_valid("t2n", -32768);

      // Voice 2 never answers: timeout after 16 WAIT cycles, missing voice counts as 0.
      bt = tmo_cnt;
      start_frame();
      give(3'b001, 100, 0, 0);
      give(3'b010, 0, 200, 0);
      for (int n = 0; n < 30 && vif.timeout_pulse !== 1'b1; n++) step();
      chk_bit("t3_timeout_seen", vif.timeout_pulse, 1'b1);
      step();
      chk_val("t3_timeout_delay", tmo_cyc - gen_cyc, 16);
      chk_val("t3_timeout_count", tmo_cnt - bt, 1);
      wait_valid("t3", 300);

      // Final capture on the expiry edge: completion wins, no timeout pulse.
      bt = tmo_cnt;
      start_frame();
      give(3'b001, 7, 0, 0);
      give(3'b010, 0, 8, 0);
      for (int n = 0; n < 13; n++) step();
      give(3'b100, 0, 0, 9);
      chk_bit("t4_no_timeout", vif.timeout_pulse, 1'b0);
      wait_valid("t4", 24);
      chk_val("t4_timeout_count", tmo_cnt - bt, 0);

      // Mute voice 1, attenuate by 4.
      vif.mute  = 3'b010;
      vif.shift = 2'd2;
      start_frame();
      give(3'b001, 400, 0, 0);
      give(3'b010, 0, 9999, 0);
      give(3'b100, 0, 0, -80);
      wait_valid("t5", 80);
      vif.mute  = 3'b000;
      vif.shift = 2'd0;

      // new_frame mid-WAIT is dropped and flagged.
      bg = gen_cnt; bv = val_cnt;
      start_frame();
      give(3'b001, 5, 0, 0);
      vif.new_frame = 1'b1;
      step();
      vif.new_frame = 1'b0;
      chk_bit("t6_overrun", vif.overrun, 1'b1);
      give(3'b110, 0, 10, 20);
      wait_valid("t6", 35);
      chk_val("t6_gen_count", gen_cnt - bg, 1);
      chk_val("t6_valid_count", val_cnt - bv, 1);
      chk_bit("t6_overrun_sticky", vif.overrun, 1'b1);

      // Reset mid-WAIT aborts the frame; the next frame starts clean.
      bv = val_cnt;
      start_frame();
      give(3'b001, 1000, 0, 0);
      reset = 1'b0;
      step();
      chk_bit("t7_busy", vif.busy, 1'b0);
      chk_bit("t7_gen", vif.generate_next, 1'b0);
      chk_bit("t7_valid", vif.sample_out_valid, 1'b0);
      chk_bit("t7_timeout", vif.timeout_pulse, 1'b0);
      chk_bit("t7_overrun", vif.overrun, 1'b0);
      chk_val("t7_sample_out", 32'(vif.sample_out), 0);
      reset = 1'b1;
      for (int n = 0; n < 20; n++) step();
      chk_val("t7_no_valid", val_cnt - bv, 0);
      start_frame();
      give(3'b001, 1, 0, 0);
      give(3'b010, 0, 2, 0);
      give(3'b100, 0, 0, 3);
      wait_valid("t7", 6);
      chk_bit("t7_overrun_after", vif.overrun, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum WAIT-state cycles before missing voices are forced to zero (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port new_frame  input  1  codec request for the next mixed sample; single-cycle pulse.
REQ-005 SHALL have port generate_next  output  1  one-cycle pulse to all three voices requesting a sample.
REQ-006 SHALL have ports ready0, ready1, ready2  input  1 each  per-voice sample-ready pulse.
REQ-007 SHALL have ports sample0, sample1, sample2  input  16 each  signed voice samples, valid while the matching ready is high.
REQ-008 SHALL have port mute  input  3  bit i set excludes voice i from the sum; sampled in SUM.
REQ-009 SHALL have port shift  input  2  arithmetic right-shift attenuation (0..3); sampled in SUM.
REQ-010 SHALL have port sample_out  output  16  signed mixed sample; held until the next update.
REQ-011 SHALL have port sample_out_valid  output  1  one-cycle pulse, sample_out is new.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port timeout_pulse  output  1  one-cycle pulse when the WAIT timer expires.
REQ-014 SHALL have port overrun  output  1  sticky; set by new_frame while busy; cleared only by reset.

Function
REQ-015 SHALL implement the states IDLE, WAIT, SUM and OUT.
REQ-016 In IDLE, new_frame high at edge k SHALL move the block to WAIT, drive generate_next high for exactly cycle k+1, clear the captured flags and the sample registers, and zero the timer.
REQ-017 In IDLE, ready0..2 SHALL be ignored.
REQ-018 In WAIT (including the generate_next cycle), a high ready_i with flag_i clear SHALL capture sample_i and set flag_i.
REQ-019 A repeated ready_i after flag_i is set SHALL be ignored; the first capture is kept.
REQ-020 When all three flags are set, counting captures made on the same edge, the next state SHALL be SUM; simultaneous readies on any subset are legal.
REQ-021 The timer SHALL increment once per WAIT cycle.
REQ-022 If the timer reaches TIMEOUT-1 with any flag still clear, the block SHALL pulse timeout_pulse, treat uncaptured voices as 0 and go to SUM.
REQ-023 If the final capture and the timer expiry occur on the same edge, completion SHALL win and timeout_pulse SHALL stay low.
REQ-024 SUM SHALL sign-extend each unmuted captured sample to 18 bits, add the three values, and arithmetic-shift the 18-bit total right by shift.
REQ-025 SUM SHALL saturate the result to [-32768, 32767], register it into sample_out, and go to OUT.
REQ-026 OUT SHALL drive sample_out_valid high for one cycle and then return to IDLE.
REQ-027 Latency: with all readies at edge m, sample_out SHALL update at edge m+1 and sample_out_valid SHALL be high during cycle m+2.
REQ-028 new_frame while busy SHALL be dropped (no queueing) and SHALL set overrun.
REQ-029 new_frame in the cycle after OUT (IDLE) SHALL be accepted normally.

Reset
REQ-030 reset low at a clock edge SHALL force IDLE, clear the flags, timer, captured samples and overrun, and hold sample_out=0, and generate_next, sample_out_valid, busy and timeout_pulse at 0.
REQ-031 reset asserted mid-WAIT or mid-SUM SHALL abort the frame with no sample_out_valid pulse; the first new_frame after release SHALL start a clean frame.

Verification
REQ-032 Bench SHALL cover: mute=0, shift=0, readies on separate cycles with samples 1000, 2000, -500 -> sample_out=2500, exactly one valid pulse, one generate_next pulse.
REQ-033 Bench SHALL cover: all three readies on the same cycle with 30000 each -> 32767; with -30000 each -> -32768.
REQ-034 Bench SHALL cover: TIMEOUT=16, ready2 never asserted, samples 100 and 200 -> timeout_pulse 16 cycles after entering WAIT, then sample_out=300.
REQ-035 Bench SHALL cover: mute=3'b010, shift=2, samples 400, 9999, -80 -> sample_out=80.
REQ-036 Bench SHALL cover: new_frame during WAIT -> overrun=1, no extra generate_next, and the frame completes normally.
REQ-037 Bench SHALL cover: reset low during WAIT -> all outputs 0, no valid pulse; the next frame with 1, 2, 3 -> 6.
